sync_filter_multi: RTL and testbench
====================================

// Module: sync_filter_multi
// PURPOSE
//   Multi-channel input conditioner: per-channel N-stage synchronizer, optional
//   stability (glitch) filter and registered rise/fall pulses. Generalises the
//   fixed 2-flop single-bit synchronizer. Sits at chip/board boundary between
//   async pins (buttons, serial lines, status strobes) and clk-domain logic.
// PARAMETERS
//   NUM_CH      4  number of independent channels (>=1)
//   SYNC_STAGES 2  flops in each sync chain (>=2)
//   FILTER_CNT  3  consecutive mismatching cycles before output follows (0 = bypass)
//   RESET_VAL   0  1-bit value of sync chain, sync_out and filter state in reset
// PORTS
//   clk        in   1       system clock, all logic on posedge
//   n_rst      in   1       reset; synchronous, active-low
//   async_in   in   NUM_CH  asynchronous inputs, one bit per channel
//   sync_out   out  NUM_CH  synchronized, filtered level
//   rise_pulse out  NUM_CH  1-cycle pulse when sync_out[i] goes 0->1
//   fall_pulse out  NUM_CH  1-cycle pulse when sync_out[i] goes 1->0
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-low (n_rst), sampled at
//     posedge clk only; no async reset path.
//   - Reset (n_rst=0 at an edge): every sync stage and sync_out <= RESET_VAL,
//     filter counters <= 0, rise_pulse/fall_pulse <= 0. Reset never makes pulses.
//   - Sync chain: stage0 <= async_in, stage[k] <= stage[k-1]; synced = last stage.
//     Change stable before edge E appears on synced after edge E+SYNC_STAGES-1.
//   - Filter (FILTER_CNT>0), per channel, each edge:
//       synced == sync_out           -> cnt <= 0
//       mismatch, cnt <  FILTER_CNT-1 -> cnt <= cnt+1
//       mismatch, cnt == FILTER_CNT-1 -> sync_out <= synced, cnt <= 0, pulse
//     i.e. FILTER_CNT consecutive mismatching edges required; any return to
//     match clears cnt. cnt width = $clog2(FILTER_CNT+1); never exceeds FILTER_CNT-1.
//   - FILTER_CNT=0: sync_out is a register on synced, pulse on every change.
//   - Latency async_in step -> sync_out: SYNC_STAGES+FILTER_CNT edges
//     (SYNC_STAGES+1 when bypassed).
//   - Pulses registered, asserted in the same cycle sync_out first shows new
//     value, high exactly one cycle; rise and fall never both high on a channel.
//   - Channels independent; simultaneous events on several channels all reported
//     in the same cycle.
//   - Glitch shorter than FILTER_CNT cycles on synced: no output change, no pulse.
//   - Reset mid-filter: in-flight count discarded; after release, a level still
//     differing from RESET_VAL is re-qualified with full latency and pulses.
// STRUCTURE
//   - sync_pkg: constant SYNC_MIN_STAGES=2, function cnt_width(FILTER_CNT).
//   - Sub-module sync_filter_ch (one channel: chain + counter + edge regs),
//     instantiated NUM_CH times by generate loop in sync_filter_multi.
//   - Elaboration-time check: SYNC_STAGES<2 or NUM_CH<1 -> $error.
// TESTING  (NUM_CH=4, SYNC_STAGES=2, FILTER_CNT=3, RESET_VAL=0 unless noted)
//   1 async_in=4'hF held through reset, release -> sync_out=0 in reset, =4'hF at
//     5th edge after release; rise_pulse=4'hF for that cycle only.
//   2 2-cycle 1-glitch on async_in[0] -> sync_out[0]=0, no pulses.
//   3 ch1 stable 1, drive 0 -> sync_out[1]=0 after 5 edges, fall_pulse=4'b0010 1 cycle.
//   4 n_rst=0 while ch2 cnt=2 -> next edge all outputs 0, no pulse; after release
//     ch2 (still 1) rises 5 edges later with rise_pulse[2].
//   5 Rebuild FILTER_CNT=0, SYNC_STAGES=3: step on ch0 -> sync_out[0] after
//     4 edges; 1-cycle glitch at stage0 propagates (no filter).
//   6 Same edge: ch2 0->1, ch3 1->0 -> rise_pulse=4'b0100, fall_pulse=4'b1000
//     in one cycle.

Source files
------------

// File: rtl/sync_filter_multi_pkg.sv
// Shared constants and helpers for the multi-channel input synchronizer/filter.
package sync_pkg;

    localparam int unsigned SYNC_MIN_STAGES = 2;

    // Width of a counter that must hold 0..filter_cnt-1; stays 1 bit when bypassed.
    function automatic int unsigned cnt_width(input int unsigned filter_cnt);
        return (filter_cnt == 0) ? 1 : $clog2(filter_cnt + 1);
    endfunction

endpackage

// File: rtl/sync_filter_multi_ch.sv
// One channel: N-flop synchronizer, optional stability counter, registered edge pulses.
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_CNT  = 3,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   synced;
    logic                   take;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
        end
    end

    assign synced = chain[SYNC_STAGES-1];

    generate
        if (FILTER_CNT == 0) begin : g_bypass
            assign take = (synced != sync_out);
        end else begin : g_filter
            localparam int unsigned    CW       = cnt_width(FILTER_CNT);
            localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CNT - 1);
            logic [CW-1:0] cnt;

            // cnt counts consecutive mismatching edges already seen; the edge
            // that would reach FILTER_CNT commits the new level instead.
            always_ff @(posedge clk) begin
                if (!n_rst) begin
                    cnt <= '0;
                end else if ((synced == sync_out) || (cnt == CNT_LAST)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign take = (synced != sync_out) && (cnt == CNT_LAST);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync_out   <= RESET_VAL;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= take & synced;
            fall_pulse <= take & ~synced;
            if (take) begin
                sync_out <= synced;
            end
        end
    end

endmodule

// File: rtl/sync_filter_multi.sv
// Multi-channel input conditioner: independent sync/filter/edge-detect per channel.
module sync_filter_multi
    import sync_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_CNT  = 3,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NUM_CH-1:0] async_in,
    output logic [NUM_CH-1:0] sync_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse
);

    generate
        if ((SYNC_STAGES < SYNC_MIN_STAGES) || (NUM_CH < 1)) begin : g_param_check
            $error("sync_filter_multi: SYNC_STAGES must be >= 2 and NUM_CH >= 1");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            sync_filter_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_CNT  (FILTER_CNT),
                .RESET_VAL   (RESET_VAL)
            ) u_ch (
                .clk        (clk),
                .n_rst      (n_rst),
                .async_in   (async_in[i]),
                .sync_out   (sync_out[i]),
                .rise_pulse (rise_pulse[i]),
                .fall_pulse (fall_pulse[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sync_filter_multi.sv
// Bench for sync_filter_multi: directed vector table plus randomized run against a history-based model.
module tb_sync_filter_multi;

    localparam int HMAX = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst  = 1'b0;
    logic       n_rst2 = 1'b0;
    logic [3:0] a      = 4'h0;
    logic [3:0] b      = 4'h0;
    logic [3:0] so1, rp1, fp1, so2, rp2, fp2;

    sync_filter_multi #(
        .NUM_CH(4), .SYNC_STAGES(2), .FILTER_CNT(3), .RESET_VAL(1'b0)
    ) u_dut (
        .clk(clk), .n_rst(n_rst), .async_in(a),
        .sync_out(so1), .rise_pulse(rp1), .fall_pulse(fp1)
    );

    sync_filter_multi #(
        .NUM_CH(4), .SYNC_STAGES(3), .FILTER_CNT(0), .RESET_VAL(1'b0)
    ) u_dut_byp (
        .clk(clk), .n_rst(n_rst2), .async_in(b),
        .sync_out(so2), .rise_pulse(rp2), .fall_pulse(fp2)
    );

    // Reference model: full per-edge history of inputs and resets. The filter sees
    // the input sampled S edges earlier (reset value if any reset touched that
    // window); the output flips once the last F seen samples all disagree with it.
    bit         rst_h [2][HMAX];
    logic [3:0] in_h  [2][HMAX];
    int         m_s   [2] = '{2, 3};
    int         m_f   [2] = '{3, 0};
    logic [3:0] m_out [2] = '{4'h0, 4'h0};
    logic [3:0] m_rise[2] = '{4'h0, 4'h0};
    logic [3:0] m_fall[2] = '{4'h0, 4'h0};
    int         edge_n = 0;

    function automatic logic [3:0] seen(input int m, input int s, input int n);
        for (int k = n - s; k <= n - 1; k++)
            if (k < 0 || rst_h[m][k]) return 4'h0;
        return in_h[m][n-s];
    endfunction

    task automatic model_step(input int m);
        logic [3:0] prev;
        logic [3:0] nxt;
        logic [3:0] sv;
        bit         all_diff;
        int         k;
        prev = m_out[m];
        if (rst_h[m][edge_n]) begin
            m_out[m] = 4'h0; m_rise[m] = 4'h0; m_fall[m] = 4'h0;
            return;
        end
        nxt = prev;
        for (int c = 0; c < 4; c++) begin
            if (m_f[m] == 0) begin
                sv = seen(m, m_s[m], edge_n);
                nxt[c] = sv[c];
            end else begin
                all_diff = 1'b1;
                for (int j = 0; j < m_f[m]; j++) begin
                    k = edge_n - j;
                    if (k < 0 || rst_h[m][k]) all_diff = 1'b0;
                    else begin
                        sv = seen(m, m_s[m], k);
                        if (sv[c] == prev[c]) all_diff = 1'b0;
                    end
                end
                if (all_diff) nxt[c] = ~prev[c];
            end
        end
        m_rise[m] = nxt & ~prev;
        m_fall[m] = ~nxt & prev;
        m_out[m]  = nxt;
    endtask

    always @(posedge clk) begin
        if (edge_n < HMAX) begin
            rst_h[0][edge_n] = !n_rst;  in_h[0][edge_n] = a;
            rst_h[1][edge_n] = !n_rst2; in_h[1][edge_n] = b;
            model_step(0);
            model_step(1);
            edge_n++;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: out/rise/fall got %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         d2;
        bit         n;
        logic [3:0] in;
        logic [3:0] o, r, f;
        string      tag;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input bit d2, input bit n, input logic [3:0] in,
                                input logic [3:0] o, input logic [3:0] r,
                                input logic [3:0] f, input string tag);
        vec_t v;
        v.d2 = d2; v.n = n; v.in = in; v.o = o; v.r = r; v.f = f; v.tag = tag;
        vq.push_back(v);
    endfunction

    function automatic void hold(input bit d2, input bit n, input logic [3:0] in,
                                 input int cnt, input logic [3:0] o, input string tag);
        for (int i = 0; i < cnt; i++) add(d2, n, in, o, 4'h0, 4'h0, tag);
    endfunction

    initial begin
        // reset held with all inputs high, then release
        hold(0, 0, 4'hF, 3, 4'h0, "t1_in_reset");
        hold(0, 1, 4'hF, 4, 4'h0, "t1_wait");
        add (0, 1, 4'hF, 4'hF, 4'hF, 4'h0, "t1_rise");
        hold(0, 1, 4'hF, 1, 4'hF, "t1_after");
        // channel 1 falls alone
        hold(0, 1, 4'hD, 4, 4'hF, "t3_wait");
        add (0, 1, 4'hD, 4'hD, 4'h0, 4'h2, "t3_fall");
        hold(0, 1, 4'hD, 1, 4'hD, "t3_after");
        hold(0, 1, 4'h0, 4, 4'hD, "clr_wait");
        add (0, 1, 4'h0, 4'h0, 4'h0, 4'hD, "clr_fall");
        hold(0, 1, 4'h0, 1, 4'h0, "clr_after");
        // two-cycle glitch on channel 0 is absorbed
        hold(0, 1, 4'h1, 2, 4'h0, "t2_glitch");
        hold(0, 1, 4'h0, 6, 4'h0, "t2_quiet");
        // simultaneous rise and fall on different channels
        hold(0, 1, 4'h8, 4, 4'h0, "t6_setup");
        add (0, 1, 4'h8, 4'h8, 4'h8, 4'h0, "t6_setup_rise");
        hold(0, 1, 4'h8, 1, 4'h8, "t6_setup_after");
        hold(0, 1, 4'h4, 4, 4'h8, "t6_wait");
        add (0, 1, 4'h4, 4'h4, 4'h4, 4'h8, "t6_both");
        hold(0, 1, 4'h4, 1, 4'h4, "t6_after");
        // reset while channel 2 is mid-qualification
        hold(0, 1, 4'h0, 4, 4'h4, "t4_clr_wait");
        add (0, 1, 4'h0, 4'h0, 4'h0, 4'h4, "t4_clr_fall");
        hold(0, 1, 4'h0, 1, 4'h0, "t4_clr_after");
        hold(0, 1, 4'h4, 4, 4'h0, "t4_count");
        hold(0, 0, 4'h4, 1, 4'h0, "t4_reset");
        hold(0, 1, 4'h4, 4, 4'h0, "t4_wait");
        add (0, 1, 4'h4, 4'h4, 4'h4, 4'h0, "t4_rise");
        hold(0, 1, 4'h4, 1, 4'h4, "t4_after");
        // bypassed filter, 3-stage chain: step then 1-cycle glitch passes through
        hold(1, 1, 4'h0, 3, 4'h0, "t5_flush");
        hold(1, 1, 4'h1, 3, 4'h0, "t5_wait");
        add (1, 1, 4'h1, 4'h1, 4'h1, 4'h0, "t5_rise");
        hold(1, 1, 4'h1, 1, 4'h1, "t5_after");
        hold(1, 1, 4'h0, 1, 4'h1, "t5_glitch");
        hold(1, 1, 4'h1, 2, 4'h1, "t5_glitch_wait");
        add (1, 1, 4'h1, 4'h0, 4'h0, 4'h1, "t5_glitch_fall");
        add (1, 1, 4'h1, 4'h1, 4'h1, 4'h0, "t5_glitch_rise");
        hold(1, 1, 4'h1, 1, 4'h1, "t5_settled");

        foreach (vq[i]) begin
            if (vq[i].d2) begin
                n_rst2 = vq[i].n; b = vq[i].in;
            end else begin
                n_rst = vq[i].n;  a = vq[i].in;
            end
            tick();
            if (vq[i].d2) check(vq[i].tag, {so2, rp2, fp2}, {vq[i].o, vq[i].r, vq[i].f});
            else          check(vq[i].tag, {so1, rp1, fp1}, {vq[i].o, vq[i].r, vq[i].f});
        end

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) a = a ^ 4'($urandom);
            if ($urandom_range(0, 3) == 0) b = b ^ 4'($urandom);
            n_rst  = ($urandom_range(0, 63) != 0);
            n_rst2 = ($urandom_range(0, 63) != 0);
            tick();
            check("rand_filt", {so1, rp1, fp1}, {m_out[0], m_rise[0], m_fall[0]});
            check("rand_byp",  {so2, rp2, fp2}, {m_out[1], m_rise[1], m_fall[1]});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
